// File: rtl/turbo_pkg.sv
// Frame geometry and encodings shared by the turbo encoder datapath (RSC encoders,
// interleaver and the output serialiser).
package turbo_pkg;

    localparam int K       = 16;
    localparam int M       = 2;
    localparam int FRAME_W = K + M;
    localparam int STEP_W  = $clog2(FRAME_W);
    localparam int CNT_W   = 16;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAME_W - 1);
    // First step that carries tail bits; tail steps are never punctured.
    localparam logic [STEP_W-1:0] TAIL_STEP = STEP_W'(K);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PH_SYS   = 2'd0,
        PH_PAR_A = 2'd1,
        PH_PAR_B = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        SEL_SYS  = 2'd0,
        SEL_PAR1 = 2'd1,
        SEL_PAR2 = 2'd2
    } word_sel_e;

    localparam phase_e PUNCT_LAST_PHASE = PH_PAR_A;
    localparam phase_e FULL_LAST_PHASE  = PH_PAR_B;

    // Step 0 carries the MSB of each word.
    function automatic logic word_bit(input logic [FRAME_W-1:0] w,
                                      input logic [STEP_W-1:0]  step);
        return w[LAST_STEP - step];
    endfunction

endpackage

// File: rtl/turbo_punct_pattern.sv
// Maps (step, phase) to the word to transmit and flags the last phase of the step.
// TURBO_PUNCT_EN selects the rate-1/2 puncturing pattern; otherwise every step is rate 1/3.
import turbo_pkg::*;

module turbo_punct_pattern (
`ifdef TURBO_PUNCT_EN
    input  logic [STEP_W-1:0] step_i,
`endif
    input  phase_e            phase_i,
    output word_sel_e         sel_o,
    output logic              last_o
);

`ifdef TURBO_PUNCT_EN
    // Info steps alternate par1/par2 on the second phase; tail steps send everything.
    always_comb begin
        sel_o  = SEL_SYS;
        last_o = 1'b0;
        if (step_i < TAIL_STEP) begin
            case (phase_i)
                PH_SYS: sel_o = SEL_SYS;
                PUNCT_LAST_PHASE: begin
                    sel_o  = step_i[0] ? SEL_PAR2 : SEL_PAR1;
                    last_o = 1'b1;
                end
                default: last_o = 1'b1;
            endcase
        end else begin
            case (phase_i)
                PH_SYS:   sel_o = SEL_SYS;
                PH_PAR_A: sel_o = SEL_PAR1;
                FULL_LAST_PHASE: begin
                    sel_o  = SEL_PAR2;
                    last_o = 1'b1;
                end
                default: last_o = 1'b1;
            endcase
        end
    end
`else
    always_comb begin
        sel_o  = SEL_SYS;
        last_o = 1'b0;
        case (phase_i)
            PH_SYS:   sel_o = SEL_SYS;
            PH_PAR_A: sel_o = SEL_PAR1;
            FULL_LAST_PHASE: begin
                sel_o  = SEL_PAR2;
                last_o = 1'b1;
            end
            default: last_o = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/turbo_punct_ser.sv
// Turbo encoder output stage: captures sys/par1/par2 frame words and serialises them MSB
// first onto a valid/ready bit stream. TURBO_PUNCT_EN enables rate-1/2 puncturing.
import turbo_pkg::*;

module turbo_punct_ser (
    input  logic               clk_p_i,
    input  logic               reset_n_i,
    input  logic               blk_valid_i,
    output logic               blk_ready_o,
    input  logic [FRAME_W-1:0] sys_i,
    input  logic [FRAME_W-1:0] par1_i,
    input  logic [FRAME_W-1:0] par2_i,
    output logic               bit_o,
    output logic               bit_valid_o,
    input  logic               bit_ready_i,
    output logic               frame_start_o,
    output logic               frame_end_o,
    output logic [CNT_W-1:0]   frame_cnt_o
);

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    phase_e             phase_q, phase_d;
    logic [FRAME_W-1:0] sys_q, sys_d;
    logic [FRAME_W-1:0] par1_q, par1_d;
    logic [FRAME_W-1:0] par2_q, par2_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    word_sel_e sel;
    logic      last_phase;
    logic      in_send;
    logic      cur_bit;

    turbo_punct_pattern u_pattern (
`ifdef TURBO_PUNCT_EN
        .step_i  (step_q),
`endif
        .phase_i (phase_q),
        .sel_o   (sel),
        .last_o  (last_phase)
    );

    // Outputs depend only on registered state, so a stalled bit holds by construction.
    always_comb begin
        in_send = (state_q == SEND);
        case (sel)
            SEL_PAR1: cur_bit = word_bit(par1_q, step_q);
            SEL_PAR2: cur_bit = word_bit(par2_q, step_q);
            default:  cur_bit = word_bit(sys_q, step_q);
        endcase
        blk_ready_o   = !in_send;
        bit_valid_o   = in_send;
        bit_o         = in_send & cur_bit;
        frame_start_o = in_send && (step_q == '0) && (phase_q == PH_SYS);
        frame_end_o   = in_send && (step_q == LAST_STEP) && last_phase;
        frame_cnt_o   = frame_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        phase_d     = phase_q;
        sys_d       = sys_q;
        par1_d      = par1_q;
        par2_d      = par2_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (blk_valid_i) begin
                    sys_d   = sys_i;
                    par1_d  = par1_i;
                    par2_d  = par2_i;
                    step_d  = '0;
                    phase_d = PH_SYS;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bit_ready_i) begin
                    if (last_phase) begin
                        phase_d = PH_SYS;
                        if (step_q == LAST_STEP) begin
                            step_d      = '0;
                            state_d     = IDLE;
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        phase_d = phase_e'(phase_q + 2'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            step_q      <= '0;
            phase_q     <= PH_SYS;
            sys_q       <= '0;
            par1_q      <= '0;
            par2_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            sys_q       <= sys_d;
            par1_q      <= par1_d;
            par2_q      <= par2_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_turbo_punct_ser.sv
// Randomised self-checking bench for turbo_punct_ser; the expected bit stream is rebuilt from
// the frame words with plain loops. Honours TURBO_PUNCT_EN like the design.
`timescale 1ns/1ps
import turbo_pkg::*;

module tb_turbo_punct_ser;

    logic               clk_p_i = 1'b0;
    logic               reset_n_i = 1'b0;
    logic               blk_valid_i = 1'b0;
    logic               blk_ready_o;
    logic [FRAME_W-1:0] sys_i = '0;
    logic [FRAME_W-1:0] par1_i = '0;
    logic [FRAME_W-1:0] par2_i = '0;
    logic               bit_o;
    logic               bit_valid_o;
    logic               bit_ready_i = 1'b0;
    logic               frame_start_o;
    logic               frame_end_o;
    logic [15:0]        frame_cnt_o;

`ifdef TURBO_PUNCT_EN
    localparam bit PUNCT = 1'b1;
`else
    localparam bit PUNCT = 1'b0;
`endif
    localparam int FRAME_BITS = PUNCT ? (2*K + 3*M) : (3*FRAME_W);

    turbo_punct_ser dut (
        .clk_p_i       (clk_p_i),
        .reset_n_i     (reset_n_i),
        .blk_valid_i   (blk_valid_i),
        .blk_ready_o   (blk_ready_o),
        .sys_i         (sys_i),
        .par1_i        (par1_i),
        .par2_i        (par2_i),
        .bit_o         (bit_o),
        .bit_valid_o   (bit_valid_o),
        .bit_ready_i   (bit_ready_i),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt = 0;
    int first_valid_cyc;
    bit exp_bits[$];
    bit got_bits[$];
    bit got_start[$];
    bit got_end[$];

    // Reference: walk positions MSB first, emitting the words each step carries.
    function automatic void build_model(input logic [FRAME_W-1:0] s,
                                        input logic [FRAME_W-1:0] p1,
                                        input logic [FRAME_W-1:0] p2);
        exp_bits.delete();
        for (int j = 0; j < FRAME_W; j++) begin
            int pos = FRAME_W - 1 - j;
            exp_bits.push_back(s[pos]);
            if (PUNCT && j < K) begin
                exp_bits.push_back((j % 2 == 0) ? p1[pos] : p2[pos]);
            end else begin
                exp_bits.push_back(p1[pos]);
                exp_bits.push_back(p2[pos]);
            end
        end
    endfunction

    task automatic send_frame(input logic [FRAME_W-1:0] s,
                              input logic [FRAME_W-1:0] p1,
                              input logic [FRAME_W-1:0] p2);
        int cyc = 0;
        @(negedge clk_p_i);
        sys_i = s;
        par1_i = p1;
        par2_i = p2;
        blk_valid_i = 1'b1;
        while (!blk_ready_o && cyc < 200) begin
            @(negedge clk_p_i);
            cyc++;
        end
        if (!blk_ready_o) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: blk_ready_o=%0b after %0d cycles, required 1", blk_ready_o, cyc);
        end
        @(posedge clk_p_i);
        #1;
        blk_valid_i = 1'b0;
    endtask

    // Gathers transferred bits; optionally stalls 3 cycles on bit index stall_at and checks hold.
    task automatic collect_frame(input bit rand_ready, input int stall_at, input int stop_after);
        int  cyc = 0;
        int  stall_n = 0;
        bit  done = 1'b0;
        logic [3:0] snap = '0;
        got_bits.delete();
        got_start.delete();
        got_end.delete();
        first_valid_cyc = -1;
        while (!done) begin
            @(negedge clk_p_i);
            if (cyc >= 2000) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL collect_timeout: got %0d bits, required frame end", got_bits.size());
                break;
            end
            if (bit_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall_at >= 0 && got_bits.size() == stall_at && bit_valid_o) begin
                if (stall_n == 0) begin
                    snap = {bit_o, bit_valid_o, frame_start_o, frame_end_o};
                end else begin
                    tests_run++;
                    if ({bit_o, bit_valid_o, frame_start_o, frame_end_o} !== snap) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_hold: outputs=%b, required %b (stall cycle %0d)",
                                 {bit_o, bit_valid_o, frame_start_o, frame_end_o}, snap, stall_n);
                    end
                end
                bit_ready_i = (stall_n >= 3);
                stall_n++;
            end else begin
                bit_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (bit_valid_o && bit_ready_i) begin
                got_bits.push_back(bit_o);
                got_start.push_back(frame_start_o);
                got_end.push_back(frame_end_o);
                if (frame_end_o) done = 1'b1;
                if (stop_after > 0 && got_bits.size() == stop_after) done = 1'b1;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_p_i);
        tests_run++;
        if ({bit_o, bit_valid_o, frame_start_o, frame_end_o, blk_ready_o} !== 5'b00001 || frame_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: bit/valid/start/end/ready=%b cnt=%0d, required 00001 cnt=0",
                     {bit_o, bit_valid_o, frame_start_o, frame_end_o, blk_ready_o}, frame_cnt_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_p_i);
        tests_run++;
        if (blk_ready_o !== 1'b1 || bit_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", blk_ready_o, bit_valid_o);
        end
        exp_cnt = 0;
    endtask

    task automatic test_directed();
        int errs = 0;
        int flag_errs = 0;
        bit head [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        build_model(18'h2AAAA, 18'h3FFFF, 18'h00000);
        send_frame(18'h2AAAA, 18'h3FFFF, 18'h00000);
        collect_frame(1'b0, -1, 0);
        exp_cnt++;
        tests_run++;
        if (first_valid_cyc !== 0) begin
            tests_failed++;
            $display("[TB] FAIL first_bit_latency: first valid at cycle %0d after accept+1, required 0", first_valid_cyc);
        end
        tests_run++;
        if (got_bits.size() != FRAME_BITS) begin
            tests_failed++;
            $display("[TB] FAIL directed_len: got %0d bits, required %0d", got_bits.size(), FRAME_BITS);
        end else begin
            for (int i = 0; i < 4; i++) if (got_bits[i] !== head[i]) errs++;
            for (int i = 0; i < FRAME_BITS; i++) begin
                if (got_bits[i] !== exp_bits[i]) errs++;
                if (got_start[i] !== (i == 0) || got_end[i] !== (i == FRAME_BITS - 1)) flag_errs++;
            end
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL directed_bits: %0d bit errors, required 0", errs);
        end
        tests_run++;
        if (flag_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL directed_flags: %0d start/end flag errors, required 0", flag_errs);
        end
        @(negedge clk_p_i);
        tests_run++;
        if (frame_cnt_o !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL directed_cnt: frame_cnt_o=%0d, required %0d", frame_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            logic [FRAME_W-1:0] s  = FRAME_W'($urandom);
            logic [FRAME_W-1:0] p1 = FRAME_W'($urandom);
            logic [FRAME_W-1:0] p2 = FRAME_W'($urandom);
            int errs = 0;
            build_model(s, p1, p2);
            send_frame(s, p1, p2);
            collect_frame(1'b1, -1, 0);
            exp_cnt++;
            if (got_bits.size() != FRAME_BITS) errs = 1000;
            else for (int i = 0; i < FRAME_BITS; i++) if (got_bits[i] !== exp_bits[i]) errs++;
            tests_run++;
            if (errs != 0) begin
                tests_failed++;
                $display("[TB] FAIL random_frame%0d: %0d errors (len %0d), required 0 (len %0d)",
                         f, errs, got_bits.size(), FRAME_BITS);
            end
            @(negedge clk_p_i);
            tests_run++;
            if (frame_cnt_o !== 16'(exp_cnt)) begin
                tests_failed++;
                $display("[TB] FAIL random_cnt%0d: frame_cnt_o=%0d, required %0d", f, frame_cnt_o, exp_cnt);
            end
        end
    endtask

    task automatic test_stall();
        logic [FRAME_W-1:0] s  = FRAME_W'($urandom);
        logic [FRAME_W-1:0] p1 = FRAME_W'($urandom);
        logic [FRAME_W-1:0] p2 = FRAME_W'($urandom);
        int errs = 0;
        build_model(s, p1, p2);
        send_frame(s, p1, p2);
        collect_frame(1'b0, 5, 0);
        exp_cnt++;
        if (got_bits.size() != FRAME_BITS) errs = 1000;
        else for (int i = 0; i < FRAME_BITS; i++) if (got_bits[i] !== exp_bits[i]) errs++;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_stream: %0d errors (len %0d), required 0 (len %0d)", errs, got_bits.size(), FRAME_BITS);
        end
        @(negedge clk_p_i);
    endtask

    task automatic test_back_to_back();
        logic [FRAME_W-1:0] as = FRAME_W'($urandom), ap1 = FRAME_W'($urandom), ap2 = FRAME_W'($urandom);
        logic [FRAME_W-1:0] bs = FRAME_W'($urandom), bp1 = FRAME_W'($urandom), bp2 = FRAME_W'($urandom);
        bit bits_a[$];
        bit bits_b[$];
        int starts[$];
        int rdy_hi = 0, overlap = 0, ends = 0, cyc = 0, errs = 0;
        @(negedge clk_p_i);
        sys_i = as; par1_i = ap1; par2_i = ap2;
        blk_valid_i = 1'b1;
        bit_ready_i = 1'b1;
        while (ends < 2 && cyc < 400) begin
            if (blk_ready_o) rdy_hi++;
            if (blk_ready_o && bit_valid_o) overlap++;
            if (frame_start_o) begin
                starts.push_back(cyc);
                if (starts.size() == 1) begin
                    sys_i = bs; par1_i = bp1; par2_i = bp2;
                end
            end
            if (bit_valid_o) begin
                if (starts.size() == 1) bits_a.push_back(bit_o);
                else bits_b.push_back(bit_o);
            end
            if (frame_end_o) ends++;
            if (ends < 2) begin
                @(negedge clk_p_i);
                cyc++;
            end
        end
        @(posedge clk_p_i);
        #1;
        blk_valid_i = 1'b0;
        exp_cnt += 2;
        tests_run++;
        if (starts.size() != 2 || (starts[1] - starts[0]) != FRAME_BITS + 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_period: %0d starts, spacing %0d, required 2 starts spacing %0d",
                     starts.size(), (starts.size() == 2) ? starts[1] - starts[0] : -1, FRAME_BITS + 1);
        end
        tests_run++;
        if (rdy_hi != 2 || overlap != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready: ready high %0d cycles, %0d during SEND, required 2 and 0", rdy_hi, overlap);
        end
        build_model(as, ap1, ap2);
        if (bits_a.size() != FRAME_BITS) errs += 1000;
        else for (int i = 0; i < FRAME_BITS; i++) if (bits_a[i] !== exp_bits[i]) errs++;
        build_model(bs, bp1, bp2);
        if (bits_b.size() != FRAME_BITS) errs += 1000;
        else for (int i = 0; i < FRAME_BITS; i++) if (bits_b[i] !== exp_bits[i]) errs++;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_streams: %0d errors, required 0", errs);
        end
        @(negedge clk_p_i);
        tests_run++;
        if (frame_cnt_o !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_cnt: frame_cnt_o=%0d, required %0d", frame_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [FRAME_W-1:0] s  = FRAME_W'($urandom);
        logic [FRAME_W-1:0] p1 = FRAME_W'($urandom);
        logic [FRAME_W-1:0] p2 = FRAME_W'($urandom);
        int errs = 0;
        send_frame(s, p1, p2);
        collect_frame(1'b0, -1, 20);
        @(negedge clk_p_i);
        reset_n_i = 1'b0;
        #1;
        exp_cnt = 0;
        tests_run++;
        if ({bit_o, bit_valid_o, frame_start_o, frame_end_o, blk_ready_o} !== 5'b00001 || frame_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state: bit/valid/start/end/ready=%b cnt=%0d, required 00001 cnt=0",
                     {bit_o, bit_valid_o, frame_start_o, frame_end_o, blk_ready_o}, frame_cnt_o);
        end
        @(negedge clk_p_i);
        reset_n_i = 1'b1;
        s = FRAME_W'($urandom);
        p1 = FRAME_W'($urandom);
        p2 = FRAME_W'($urandom);
        build_model(s, p1, p2);
        send_frame(s, p1, p2);
        collect_frame(1'b1, -1, 0);
        exp_cnt++;
        if (got_bits.size() != FRAME_BITS || got_start[0] !== 1'b1) errs = 1000;
        else for (int i = 0; i < FRAME_BITS; i++) if (got_bits[i] !== exp_bits[i]) errs++;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next_frame: %0d errors (len %0d), required 0 (len %0d)", errs, got_bits.size(), FRAME_BITS);
        end
        @(negedge clk_p_i);
        tests_run++;
        if (frame_cnt_o !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_cnt: frame_cnt_o=%0d, required %0d", frame_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        @(negedge clk_p_i);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk_p_i);
        release dut.frame_cnt_q;
        @(negedge clk_p_i);
        tests_run++;
        if (frame_cnt_o !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL wrap_preload: frame_cnt_o=%h, required ffff", frame_cnt_o);
        end
        send_frame(FRAME_W'($urandom), FRAME_W'($urandom), FRAME_W'($urandom));
        collect_frame(1'b0, -1, 0);
        @(negedge clk_p_i);
        tests_run++;
        if (frame_cnt_o !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL wrap_cnt: frame_cnt_o=%h, required 0000", frame_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_frames();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
